// File: rtl/obi_xbar_n_to_one_outstanding.sv
// N-to-1 OBI crossbar with round-robin arbitration and an in-order ID FIFO.
// Multiple transactions can be in flight at once. Each response is routed to the
// master recorded at the FIFO head.
module obi_xbar_n_to_one_outstanding #(
   parameter int unsigned NumMasters     = 2,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned IdxWidth       = $clog2(NumMasters)
) (
   input  logic                                         clk_i,
   input  logic                                         rst_ni,
   input  logic [NumMasters-1:0]                        master_req_i,
   input  logic [NumMasters-1:0]                        master_we_i,
   input  logic [NumMasters-1:0][DataWidth/8-1:0]       master_be_i,
   input  logic [NumMasters-1:0][AddrWidth-1:0]         master_addr_i,
   input  logic [NumMasters-1:0][DataWidth-1:0]         master_wdata_i,
   output logic [NumMasters-1:0]                        master_gnt_o,
   output logic [NumMasters-1:0]                        master_rvalid_o,
   output logic [NumMasters-1:0][DataWidth-1:0]         master_rdata_o,
   output logic                                         slave_req_o,
   output logic                                         slave_we_o,
   output logic [DataWidth/8-1:0]                       slave_be_o,
   output logic [AddrWidth-1:0]                         slave_addr_o,
   output logic [DataWidth-1:0]                         slave_wdata_o,
   input  logic                                         slave_gnt_i,
   input  logic                                         slave_rvalid_i,
   input  logic [DataWidth-1:0]                         slave_rdata_i,
   output logic [$clog2(MaxOutstanding+1)-1:0]          outstanding_o,
   output logic                                         err_o
);

   localparam int unsigned CntWidth = $clog2(MaxOutstanding+1);
   localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

   logic [IdxWidth-1:0]                      rr_q;
   logic                                     lock_q;
   logic [IdxWidth-1:0]                      lock_idx_q;
   logic [MaxOutstanding-1:0][IdxWidth-1:0]  fifo_q;
   logic [PtrWidth-1:0]                      wr_ptr_q, rd_ptr_q;
   logic [CntWidth-1:0]                      count_q;

   logic                arb_found;
   logic [IdxWidth-1:0] arb_idx;
   logic [IdxWidth:0]   cand;
   logic [IdxWidth-1:0] sel;
   logic                sel_req, active;
   logic                full, empty;
   logic                push, pop;
   logic [IdxWidth-1:0] head;

   // Round-robin search: first requester at or after rr_q wins
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NumMasters; i++) begin
         cand = {1'b0, rr_q} + (IdxWidth+1)'(i);
         if (cand >= (IdxWidth+1)'(NumMasters)) cand = cand - (IdxWidth+1)'(NumMasters);
         if (!arb_found && master_req_i[cand[IdxWidth-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = cand[IdxWidth-1:0];
         end
      end
   end

   // A locked selection wins over fresh arbitration so OBI payload stays stable
   assign sel     = lock_q ? lock_idx_q : arb_idx;
   assign sel_req = lock_q ? master_req_i[lock_idx_q] : arb_found;
   assign active  = sel_req && rst_ni;

   assign full  = (count_q == CntWidth'(MaxOutstanding));
   assign empty = (count_q == '0);

   // Gate on full only (not on a same-cycle pop) to keep rvalid->req path out
   assign slave_req_o = active && !full;
   assign push        = slave_req_o && slave_gnt_i;
   assign pop         = slave_rvalid_i && !empty && rst_ni;
   assign err_o       = slave_rvalid_i && empty && rst_ni;
   assign head        = fifo_q[rd_ptr_q];

   assign outstanding_o = count_q;

   // Request payload from the selected master, zero when nothing is selected
   always_comb begin
      slave_we_o    = 1'b0;
      slave_be_o    = '0;
      slave_addr_o  = '0;
      slave_wdata_o = '0;
      if (active) begin
         slave_we_o    = master_we_i[sel];
         slave_be_o    = master_be_i[sel];
         slave_addr_o  = master_addr_i[sel];
         slave_wdata_o = master_wdata_i[sel];
      end
   end

   // Grant only the selected master, combinationally from slave_gnt_i
   always_comb begin
      master_gnt_o      = '0;
      master_gnt_o[sel] = push;
   end

   // Route the response to the master at the FIFO head
   always_comb begin
      master_rvalid_o = '0;
      master_rdata_o  = '0;
      if (pop) begin
         master_rvalid_o[head] = 1'b1;
         master_rdata_o[head]  = slave_rdata_i;
      end
   end

   // ID FIFO, in-flight count, round-robin pointer and selection lock
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         fifo_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= sel;
            wr_ptr_q <= (wr_ptr_q == PtrWidth'(MaxOutstanding-1)) ? '0 : wr_ptr_q + 1'b1;
            rr_q     <= (sel == IdxWidth'(NumMasters-1)) ? '0 : sel + 1'b1;
            lock_q   <= 1'b0;
         end else if (sel_req) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel;
         end else begin
            lock_q <= 1'b0;
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PtrWidth'(MaxOutstanding-1)) ? '0 : rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (!push && pop) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule

// File: doc/obi_xbar_n_to_one_outstanding.md
Name: obi_xbar_n_to_one_outstanding

Overview:
- N-to-1 OBI crossbar with round-robin arbitration and support for up to MaxOutstanding in-flight transactions.
- Does not block after each grant. Records the granted master index in an in-order ID FIFO and routes each slave rvalid/rdata to the FIFO head.
- Sits at the neck between several bus masters and one slave port (memory bank or peripheral bus).
- MaxOutstanding=1 gives the one-transaction-at-a-time behaviour.

Parameters:
- NumMasters, 2, number of master ports (>=2).
- AddrWidth, 32, address width.
- DataWidth, 32, data width. Byte-enable width is DataWidth/8.
- MaxOutstanding, 2, ID FIFO depth (>=1). Maximum granted-but-not-responded transactions.
- IdxWidth, $clog2(NumMasters), master index width (derived).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- master_req_i  in  NumMasters  per-master OBI req
- master_we_i  in  NumMasters  per-master write enable
- master_be_i  in  NumMasters x DataWidth/8  per-master byte enables
- master_addr_i  in  NumMasters x AddrWidth  per-master address
- master_wdata_i  in  NumMasters x DataWidth  per-master write data
- master_gnt_o  out  NumMasters  per-master grant
- master_rvalid_o  out  NumMasters  per-master response valid
- master_rdata_o  out  NumMasters x DataWidth  per-master read data
- slave_req_o  out  1  slave request
- slave_we_o / slave_be_o / slave_addr_o / slave_wdata_o  out  1 / DataWidth/8 / AddrWidth / DataWidth  muxed request payload
- slave_gnt_i  in  1  slave grant
- slave_rvalid_i  in  1  slave response valid
- slave_rdata_i  in  DataWidth  slave read data
- outstanding_o  out  $clog2(MaxOutstanding+1)  current in-flight count
- err_o  out  1  one-cycle pulse: rvalid received with empty FIFO

Behaviour:
- Reset (async, rst_ni=0): FIFO empty, outstanding_o=0, RR pointer=0, lock cleared. All gnt/rvalid outputs, slave_req_o and err_o are 0. Payload outputs are 0. Reset mid-transaction discards all in-flight IDs.
- Arbitration is round-robin. Search starts at the RR pointer over master_req_i; the first requester wins.
- Lock: if the winner's req is high but not granted, the selection is registered (lock_q, lock_idx_q) and held until its handshake. Other masters cannot preempt it. OBI requires req/payload stable until gnt.
- full = (outstanding == MaxOutstanding).
- slave_req_o = any selected req && !full.
- Payload is muxed from the selected master, whether locked or freshly arbitrated.
- master_gnt_o[sel] = slave_gnt_i && slave_req_o. All other grants are 0. Grant is combinational from slave_gnt_i (zero added latency).
- On handshake (slave_req_o && slave_gnt_i):
  - push sel into the FIFO;
  - RR pointer <= sel+1, wrapping at NumMasters;
  - lock cleared.
- Response: when slave_rvalid_i=1 and the FIFO is non-empty, pop the head h. master_rvalid_o[h]=1 and master_rdata_o[h]=slave_rdata_i in the same cycle (combinational). Other rvalids are 0. rdata of non-addressed masters is 0.
- rvalid with empty FIFO: no master rvalid, err_o=1 for that cycle, state unchanged.
- Simultaneous push and pop: count unchanged. FIFO pointers both advance. Wrap-around is at MaxOutstanding.
- Full: slave_req_o is gated even if a pop occurs that cycle. This avoids a combinational rvalid->req path, so a freed slot is usable the next cycle.
- Responses are strictly in order. The slave must return responses in grant order.
- No master request is ever dropped: a master whose req is high is granted within NumMasters handshakes once not full.

Test Plan:
- Single master 0, MaxOutstanding=2, slave gnt always 1, rvalid 2 cycles after gnt, 3 back-to-back reads:
  - first 2 granted on consecutive cycles; third held until the first rvalid frees a slot (granted the cycle after);
  - rvalid/rdata return only on master 0.
- Masters 0 and 1 request continuously, NumMasters=2, immediate gnt, single-cycle rvalid:
  - grants alternate 0,1,0,1;
  - responses 0xA0,0xB1,... routed to the matching master in order.
- Lock: master 2 selected, slave_gnt_i=0 for 3 cycles while master 0 raises req:
  - payload and slave_addr_o stay master 2's (e.g. 0x1000) until gnt;
  - master 0 is granted next.
- Full plus same-cycle rvalid, MaxOutstanding=1, req pending when rvalid arrives:
  - no grant that cycle; grant the next cycle; outstanding_o goes 1 -> 0 -> 1.
- Spurious slave_rvalid_i with FIFO empty -> err_o pulses 1 cycle, all master_rvalid_o=0, outstanding_o stays 0.
- Assert rst_ni low with 2 transactions in flight -> outputs 0 immediately.
  - After release, new requests arbitrate from master 0.
  - A later stray rvalid raises err_o.
